// File: rtl/decoder_stream.sv
// Streaming decoder: unpacks words of 4-bit sign-magnitude codes into
// OUT_LANES two's-complement values (2x code) per valid/ready beat.
module decoder_stream #(
  parameter int N_CODES   = 8,
  parameter int OUT_LANES = 2,
  parameter int OUT_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [4*N_CODES-1:0]       in_data_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_LANES*OUT_W-1:0] out_data_o,
  output logic                       out_last_o,
  output logic                       out_err_o
);

  localparam int BEATS = N_CODES / OUT_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [4*N_CODES-1:0]   word_q, word_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic                   final_beat, accept, advance;

  assign final_beat  = (beat_q == CNT_W'(BEATS - 1));
  assign out_valid_o = (state_q == HOLD);
  // Ready during the final-beat handshake lets the next word land with no bubble.
  assign in_ready_o  = (state_q == EMPTY) || (out_valid_o && final_beat && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign advance     = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = HOLD;
      word_d  = in_data_i;
      last_d  = in_last_i;
      beat_d  = '0;
    end else if (advance) begin
      if (final_beat) state_d = EMPTY;
      else            beat_d  = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      word_q  <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  logic [3:0]       code;
  logic [OUT_W-1:0] mag;
  logic             illegal;
  int unsigned      idx;

  always_comb begin
    out_data_o = '0;
    out_err_o  = 1'b0;
    out_last_o = out_valid_o && last_q && final_beat;
    code       = '0;
    mag        = '0;
    illegal    = 1'b0;
    idx        = 0;
    if (out_valid_o) begin
      for (int unsigned j = 0; j < OUT_LANES; j++) begin
        idx     = 32'(beat_q) * OUT_LANES + j;
        code    = word_q[idx*4 +: 4];
        // Magnitudes 5..7 have no encoder source; flag and zero the lane.
        illegal = code[2] && (code[1] || code[0]);
        mag     = OUT_W'({code[2:0], 1'b0});
        out_data_o[j*OUT_W +: OUT_W] = illegal ? '0 : (code[3] ? -mag : mag);
        out_err_o = out_err_o || illegal;
      end
    end
  end

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream: directed scenarios plus random
// traffic against a beat-queue reference model.
module tb_decoder_stream;

  localparam int N_CODES = 8, OUT_LANES = 2, OUT_W = 8, BEATS = 4;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_last_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o, out_valid_o, out_last_o, out_err_o;
  logic [15:0] out_data_o;

  decoder_stream #(.N_CODES(N_CODES), .OUT_LANES(OUT_LANES), .OUT_W(OUT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_last_i(in_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .out_err_o(out_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [15:0] data; logic err; logic last; } beat_t;
  beat_t expq[$];

  int total = 0, bad = 0;
  logic o_valid, o_ready, o_last, o_err;
  logic [15:0] o_data;
  logic e_valid, e_ready;
  beat_t e_beat;

  function automatic int code_value(input logic [3:0] c);
    int m = int'(c[2:0]);
    if (m > 4) return 0;
    return c[3] ? -2 * m : 2 * m;
  endfunction

  function automatic beat_t ref_beat(input logic [31:0] w, input int k, input logic il);
    beat_t b;
    logic [3:0] c;
    int v;
    b.data = '0;
    b.err  = 1'b0;
    for (int j = 0; j < OUT_LANES; j++) begin
      c = w[4*(k*OUT_LANES+j) +: 4];
      v = code_value(c);
      b.data[8*j +: 8] = v[7:0];
      if (int'(c[2:0]) > 4) b.err = 1'b1;
    end
    b.last = il && (k == BEATS - 1);
    return b;
  endfunction

  // Drive one cycle at the falling edge, sample after settling, advance model at the rising edge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] d,
                      input logic il, input logic ordy);
    @(negedge clk_i);
    rst_i = rst; in_valid_i = iv; in_data_i = d; in_last_i = il; out_ready_i = ordy;
    #1;
    e_valid = (expq.size() != 0);
    e_ready = (expq.size() == 0) || (expq.size() == 1 && ordy);
    if (e_valid) e_beat = expq[0];
    o_valid = out_valid_o; o_ready = in_ready_o; o_data = out_data_o;
    o_last = out_last_o; o_err = out_err_o;
    @(posedge clk_i);
    if (rst) expq.delete();
    else begin
      if (e_valid && ordy) void'(expq.pop_front());
      if (iv && e_ready)
        for (int k = 0; k < BEATS; k++) expq.push_back(ref_beat(d, k, il));
    end
  endtask

  task automatic test_reset();
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    total++; if ({o_data, o_last, o_err} !== 18'h0) begin bad++;
      $display("FAIL reset_outs got=%h/%0b/%0b exp=0/0/0", o_data, o_last, o_err); end
  endtask

  task automatic test_basic();
    logic [15:0] tbl [4];
    int k = 0;
    tbl = '{16'h0402, 16'h0806, 16'h02F8, 16'h0000};
    for (int c = 0; c < 6; c++) begin
      step(0, c == 0, 32'h0F1C4321, 1, 1);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL basic_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL basic_ready cyc=%0d got=%0b exp=%0b", c, o_ready, e_ready); end
      if (o_valid && k < 4) begin
        total++; if (o_data !== tbl[k]) begin bad++; $display("FAIL basic_data beat=%0d got=%h exp=%h", k, o_data, tbl[k]); end
        total++; if ({o_err, o_last} !== ((k == 3) ? 2'b11 : 2'b00)) begin bad++;
          $display("FAIL basic_flags beat=%0d got=%0b%0b exp=%0b", k, o_err, o_last, k == 3); end
        k++;
      end
    end
    total++; if (k !== 4) begin bad++; $display("FAIL basic_beats got=%0d exp=4", k); end
  endtask

  task automatic test_backpressure();
    logic pat [7];
    int hs = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 9; c++) begin
      step(0, c == 0, 32'h0F1C4321, 1, (c >= 1 && c <= 7) ? pat[c-1] : 1'b1);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b exp=%0b", c, o_ready, e_ready); end
      if (e_valid) begin
        total++; if ({o_data, o_err, o_last} !== {e_beat.data, e_beat.err, e_beat.last}) begin bad++;
          $display("FAIL bp_beat cyc=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, o_data, o_err, o_last, e_beat.data, e_beat.err, e_beat.last); end
      end
      if (o_valid && out_ready_i) hs++;
    end
    total++; if (hs !== 4) begin bad++; $display("FAIL bp_handshakes got=%0d exp=4", hs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2];
    int sent = 0, nv = 0, first_v = -1, last_v = -1, acc_b = -1;
    w = '{32'h84213210, 32'h0C0B0A09};
    for (int c = 0; c < 11; c++) begin
      step(0, sent < 2, w[sent < 2 ? sent : 1], sent == 1, 1);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", c, o_ready, e_ready); end
      if (e_valid) begin
        total++; if ({o_data, o_err, o_last} !== {e_beat.data, e_beat.err, e_beat.last}) begin bad++;
          $display("FAIL b2b_beat cyc=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, o_data, o_err, o_last, e_beat.data, e_beat.err, e_beat.last); end
      end
      if (o_valid) begin nv++; if (first_v < 0) first_v = c; last_v = c; end
      if (sent == 1 && o_ready) acc_b = c;
      if (sent < 2 && e_ready) sent++;
    end
    total++; if (nv !== 8 || first_v !== 1 || last_v !== 8) begin bad++;
      $display("FAIL b2b_run got=%0d beats cyc %0d..%0d exp=8 beats cyc 1..8", nv, first_v, last_v); end
    total++; if (acc_b !== 4) begin bad++; $display("FAIL b2b_capture got=%0d exp=4", acc_b); end
  endtask

  task automatic test_sweep();
    logic [31:0] w [2];
    int sent = 0;
    w = '{32'h76543210, 32'hFEDCBA98};
    for (int c = 0; c < 30; c++) begin
      step(0, sent < 2, w[sent < 2 ? sent : 1], 1'($urandom_range(0, 1)), ($urandom % 3) != 0);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL sweep_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL sweep_ready cyc=%0d got=%0b exp=%0b", c, o_ready, e_ready); end
      if (e_valid) begin
        total++; if ({o_data, o_err, o_last} !== {e_beat.data, e_beat.err, e_beat.last}) begin bad++;
          $display("FAIL sweep_beat cyc=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, o_data, o_err, o_last, e_beat.data, e_beat.err, e_beat.last); end
      end
      if (sent < 2 && e_ready) sent++;
    end
  endtask

  task automatic test_reset_mid_word();
    step(0, 1, 32'h44332211, 1, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", o_ready); end
    for (int c = 0; c < 6; c++) begin
      step(0, c == 0, 32'h0C0B4321, 0, 1);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rstmid_v2 cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      if (e_valid) begin
        total++; if ({o_data, o_err, o_last} !== {e_beat.data, e_beat.err, e_beat.last}) begin bad++;
          $display("FAIL rstmid_beat cyc=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, o_data, o_err, o_last, e_beat.data, e_beat.err, e_beat.last); end
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [3:0] rc [16];
    int rexp [16];
    int got [$];
    logic [31:0] w [2];
    int sent = 0, x, t, e;
    logic signed [7:0] lane;
    // Encoder rounds x/2 half-up: e = floor((x+1)/2).
    for (int i = 0; i < 16; i++) begin
      x = i - 8; t = x + 1;
      e = (t >= 0) ? t / 2 : -((1 - t) / 2);
      rexp[i] = 2 * e;
      rc[i] = {e < 0, 3'((e < 0) ? -e : e)};
    end
    for (int i = 0; i < 8; i++) begin w[0][4*i +: 4] = rc[i]; w[1][4*i +: 4] = rc[i+8]; end
    for (int c = 0; c < 12; c++) begin
      step(0, sent < 2, w[sent < 2 ? sent : 1], 0, 1);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rt_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      if (o_valid) begin
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rt_err cyc=%0d got=%0b exp=0", c, o_err); end
        for (int j = 0; j < 2; j++) begin lane = o_data[8*j +: 8]; got.push_back(int'(lane)); end
      end
      if (sent < 2 && e_ready) sent++;
    end
    total++; if (got.size() !== 16) begin bad++; $display("FAIL rt_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      total++; if (got[i] !== rexp[i]) begin bad++; $display("FAIL rt_value in=%0d got=%0d exp=%0d", i - 8, got[i], rexp[i]); end
    end
  endtask

  task automatic test_random();
    int guard = 0;
    for (int c = 0; c < 400; c++) begin
      step(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ($urandom % 4) != 0);
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, o_valid, e_valid); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, o_ready, e_ready); end
      if (e_valid) begin
        total++; if ({o_data, o_err, o_last} !== {e_beat.data, e_beat.err, e_beat.last}) begin bad++;
          $display("FAIL rand_beat cyc=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", c, o_data, o_err, o_last, e_beat.data, e_beat.err, e_beat.last); end
      end else begin
        total++; if ({o_data, o_err, o_last} !== 18'h0) begin bad++; $display("FAIL rand_idle cyc=%0d got=%h/%0b/%0b exp=0", c, o_data, o_err, o_last); end
      end
    end
    while (expq.size() != 0 && guard < 10) begin
      step(0, 0, '0, 0, 1);
      guard++;
      total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rand_drain got=%0b exp=%0b", o_valid, e_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    test_reset_mid_word();
    test_roundtrip();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
